// File: rtl/dpll_pkg.sv
// ----------------------------------------------------------------------------
// dpll_pkg
// Shared types and helpers for the DPLL blocks.
//   idc_state_t : ID counter state (normal run / one-cycle high-phase stretch)
//   idc_cnt_w() : width of the ID counter phase register for a given half period
// ----------------------------------------------------------------------------
package dpll_pkg;

    typedef enum logic {
        IDC_RUN     = 1'b0,
        IDC_STRETCH = 1'b1
    } idc_state_t;

    // Phase counter runs 0..2*H-1.
    function automatic int idc_cnt_w(input int half_period);
        return $clog2(2 * half_period);
    endfunction

endpackage

// File: rtl/dpll_id_counter_if.sv
// ----------------------------------------------------------------------------
// dpll_id_counter_if
// Request/response bundle between the loop filter and the ID counter.
//   inc, dec : loop filter -> counter, advance / retard requests
//   freeze   : loop filter -> counter, holdover (only with DPLL_IDC_FREEZE_EN)
//   id_out   : counter -> divider, ID clock
//   pend_o   : counter -> observer, signed corrections not yet applied
//   drop_o   : counter -> observer, request discarded on saturation
// Modports: master = loop filter side, slave = ID counter side.
// ----------------------------------------------------------------------------
interface dpll_id_counter_if #(
    parameter int PEND_W = 4
);
    logic              inc;
    logic              dec;
    logic              id_out;
    logic [PEND_W-1:0] pend_o;
    logic              drop_o;
`ifdef DPLL_IDC_FREEZE_EN
    logic              freeze;

    modport master (output inc, dec, freeze, input  id_out, pend_o, drop_o);
    modport slave  (input  inc, dec, freeze, output id_out, pend_o, drop_o);
`else
    modport master (output inc, dec, input  id_out, pend_o, drop_o);
    modport slave  (input  inc, dec, output id_out, pend_o, drop_o);
`endif
endinterface

// File: rtl/dpll_pend_acc.sv
// ----------------------------------------------------------------------------
// dpll_pend_acc
// Signed saturating accumulator of corrections waiting to be applied.
//   clk_in, rst_n   : clock, async active-low reset
//   i_inc, i_dec    : new advance / retard request this cycle
//   i_consume_up    : one pending advance is applied this cycle (pend -= 1)
//   i_consume_dn    : one pending retard is applied this cycle (pend += 1)
//   i_clear         : zero the accumulator on the next edge
//   o_pend          : signed pending count, limited to +/-(2**(PEND_W-1)-1)
//   o_drop          : registered pulse, a request was discarded
// ----------------------------------------------------------------------------
module dpll_pend_acc #(
    parameter int PEND_W = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     i_inc,
    input  logic                     i_dec,
    input  logic                     i_consume_up,
    input  logic                     i_consume_dn,
    input  logic                     i_clear,
    output logic signed [PEND_W-1:0] o_pend,
    output logic                     o_drop
);
    localparam logic signed [PEND_W:0] PMAX = (PEND_W+1)'(2**(PEND_W-1) - 1);

    logic signed [PEND_W-1:0] r_pend;
    logic                     r_drop;
    logic        [PEND_W:0]   w_adj;
    logic signed [PEND_W:0]   w_net;
    logic                     w_ovf;

    // One extra bit holds pend +/- 1 without wrapping. Consumption always moves
    // pend toward zero, so an overflow can only occur when nothing was consumed;
    // holding pend on overflow therefore never loses an applied correction.
    always_comb begin
        w_adj = (PEND_W+1)'(i_inc) - (PEND_W+1)'(i_dec)
              - (PEND_W+1)'(i_consume_up) + (PEND_W+1)'(i_consume_dn);
        w_net = $signed({r_pend[PEND_W-1], r_pend} + w_adj);
        w_ovf = (w_net > PMAX) || (w_net < -PMAX);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_drop <= 1'b0;
        end else if (i_clear) begin
            r_pend <= '0;
            r_drop <= 1'b0;
        end else if (w_ovf) begin
            r_drop <= 1'b1;
        end else begin
            r_pend <= w_net[PEND_W-1:0];
            r_drop <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_drop = r_drop;
endmodule

// File: rtl/dpll_id_counter.sv
// ----------------------------------------------------------------------------
// dpll_id_counter
// DPLL increment/decrement counter. Produces id_out, a clk_in/(2*HALF_PERIOD)
// square wave; each accepted inc advances it by one clk_in period, each dec
// retards it by one. At most one correction is applied per id_out period, at
// the wrap point: an advance drops cnt value 0 (short low phase), a retard
// repeats cnt value 2H-1 (long high phase), so the high phase is never shortened.
//   clk_in : clock
//   rst_n  : async active-low reset
//   bus    : dpll_id_counter_if.slave (inc, dec, [freeze], id_out, pend_o, drop_o)
// Optional feature: DPLL_IDC_FREEZE_EN adds bus.freeze (holdover: requests
// ignored, pending cleared, nominal period; a stretch in progress completes).
// ----------------------------------------------------------------------------
module dpll_id_counter
    import dpll_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int PEND_W      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    dpll_id_counter_if.slave      bus
);
    localparam int            CW   = idc_cnt_w(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(2*HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF = CW'(HALF_PERIOD);

    idc_state_t               r_state, w_state_nxt;
    logic [CW-1:0]            r_cnt, w_cnt_nxt;
    logic                     r_id;
    logic                     w_id_nxt;
    logic                     w_freeze;
    logic                     w_wrap;
    logic                     w_pend_pos, w_pend_neg;
    logic                     w_consume_up, w_consume_dn;
    logic signed [PEND_W-1:0] w_pend;
    logic                     w_drop;

`ifdef DPLL_IDC_FREEZE_EN
    assign w_freeze = bus.freeze;
`else
    assign w_freeze = 1'b0;
`endif

    assign w_pend_neg = w_pend[PEND_W-1];
    assign w_pend_pos = !w_pend[PEND_W-1] && (w_pend != '0);
    assign w_wrap     = (r_state == IDC_RUN) && (r_cnt == LAST);

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDC_RUN;
            r_cnt   <= '0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // Next state; in holdover the wrap behaves as if nothing were pending
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        case (r_state)
            IDC_RUN: begin
                if (r_cnt == LAST) begin
                    if (!w_freeze && w_pend_pos) begin
                        w_cnt_nxt = CW'(1);
                    end else if (!w_freeze && w_pend_neg) begin
                        w_cnt_nxt   = LAST;
                        w_state_nxt = IDC_STRETCH;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            IDC_STRETCH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDC_RUN;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDC_RUN;
            end
        endcase
    end

    // Outputs: correction consumption and registered id_out source
    always_comb begin
        w_consume_up = w_wrap && !w_freeze && w_pend_pos;
        w_consume_dn = w_wrap && !w_freeze && w_pend_neg;
        w_id_nxt     = (w_cnt_nxt >= HALF);
    end

    dpll_pend_acc #(.PEND_W(PEND_W)) u_pend_acc (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .i_inc        (bus.inc && !w_freeze),
        .i_dec        (bus.dec && !w_freeze),
        .i_consume_up (w_consume_up),
        .i_consume_dn (w_consume_dn),
        .i_clear      (w_freeze),
        .o_pend       (w_pend),
        .o_drop       (w_drop)
    );

    assign bus.id_out = r_id;
    assign bus.pend_o = w_pend;
    assign bus.drop_o = w_drop;
endmodule

// File: tb/tb_dpll_id_counter.sv
// ----------------------------------------------------------------------------
// tb_dpll_id_counter
// Self-checking bench for dpll_id_counter (HALF_PERIOD=2, PEND_W=4).
// Reference model: id_out = ((t + off) mod 2H) >= H, where t counts cycles
// since reset and off is the net number of applied corrections; pending is a
// plain integer with clamp-by-rejection at +/-PMAX.
// ----------------------------------------------------------------------------
module tb_dpll_id_counter;
    localparam int H    = 2;
    localparam int PW   = 4;
    localparam int PMAX = 7;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    dpll_id_counter_if #(.PEND_W(PW)) bus ();

    dpll_id_counter #(.HALF_PERIOD(H), .PEND_W(PW)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

`ifdef DPLL_IDC_FREEZE_EN
    initial bus.freeze = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_t, m_off, m_pend, m_applied;
    bit m_stretch, m_drop;

    function automatic int m_phase();
        return (m_t + m_off) % (2*H);
    endfunction

    task automatic model_reset();
        m_t = 0; m_off = 0; m_pend = 0; m_applied = 0;
        m_stretch = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit i, input bit d);
        int cons, net;
        cons = 0;
        if (m_stretch) begin
            m_stretch = 0;
        end else if (m_phase() == 2*H-1 && m_pend != 0) begin
            m_applied++;
            if (m_pend > 0) begin cons = 1;  m_off++; end
            else            begin cons = -1; m_off--; m_stretch = 1; end
        end
        m_t++;
        net = m_pend + int'(i) - int'(d) - cons;
        if (net > PMAX || net < -PMAX) m_drop = 1;
        else begin m_pend = net; m_drop = 0; end
    endtask

    // ---------------- observation ----------------
    int cyc, last_rise;
    bit prev_id;
    int pers[$];
    int his[$];

    function automatic int cnt_ne(input int q[$], input int v);
        int n = 0;
        foreach (q[k]) if (q[k] != v) n++;
        return n;
    endfunction

    function automatic int cnt_eq(input int q[$], input int v);
        int n = 0;
        foreach (q[k]) if (q[k] == v) n++;
        return n;
    endfunction

    function automatic int pend_obs();
        return int'($signed(bus.pend_o));
    endfunction

    // Drive at negedge, model at posedge, compare at the following negedge.
    task automatic step(input bit i, input bit d);
        bus.inc = i; bus.dec = d;
        @(posedge clk_in);
        model_step(i, d);
        @(negedge clk_in);
        bus.inc = 1'b0; bus.dec = 1'b0;
        cyc++;
        chk("id_out", int'(bus.id_out), int'(m_phase() >= H));
        chk("pend_o", pend_obs(), m_pend);
        chk("drop_o", int'(bus.drop_o), int'(m_drop));
        if (bus.id_out && !prev_id) begin
            pers.push_back(cyc - last_rise);
            last_rise = cyc;
        end
        if (!bus.id_out && prev_id) his.push_back(cyc - last_rise);
        prev_id = bus.id_out;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        bus.inc = 1'b0; bus.dec = 1'b0;
        #1;
        chk("rst_id", int'(bus.id_out), 0);
        chk("rst_pend", pend_obs(), 0);
        chk("rst_drop", int'(bus.drop_o), 0);
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc = 0; last_rise = 0; prev_id = 0;
        pers.delete(); his.delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops, a0, maxp, waited, mode;
        bus.inc = 1'b0; bus.dec = 1'b0;
        model_reset();
        cyc = 0; last_rise = 0; prev_id = 0;

        // Free-running after reset
        do_reset();
        step(0, 0);
        chk("first_low", int'(bus.id_out), 0);
        step(0, 0);
        chk("first_rise", int'(bus.id_out), 1);
        pers.delete(); his.delete();
        idle(38);
        chk("idle_per", cnt_ne(pers, 4), 0);
        chk("idle_hi", cnt_ne(his, 2), 0);
        chk("idle_nper", int'(pers.size() >= 8), 1);

        // Single advance
        pers.delete(); his.delete();
        step(1, 0);
        chk("inc_pend", pend_obs(), 1);
        idle(16);
        chk("inc_p3", cnt_eq(pers, 3), 1);
        chk("inc_p4", cnt_ne(pers, 4), 1);
        chk("inc_drain", pend_obs(), 0);

        // Single retard
        pers.delete(); his.delete();
        step(0, 1);
        chk("dec_pend", int'(bus.pend_o), 15);
        idle(16);
        chk("dec_p5", cnt_eq(pers, 5), 1);
        chk("dec_h3", cnt_eq(his, 3), 1);
        chk("dec_drain", pend_obs(), 0);

        // Simultaneous inc/dec cancel
        pers.delete(); his.delete();
        drops = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 1);
            drops += int'(bus.drop_o);
        end
        idle(4);
        chk("both_drop", drops, 0);
        chk("both_per", cnt_ne(pers, 4), 0);

        // Held inc: saturation accounting
        drops = 0; maxp = 0; a0 = m_applied;
        for (int k = 0; k < 12; k++) begin
            step(1, 0);
            drops += int'(bus.drop_o);
            if (pend_obs() > maxp) maxp = pend_obs();
        end
        chk("sat_max", int'(maxp > PMAX), 0);
        chk("sat_hit", maxp, PMAX);
        chk("sat_sum", drops + (m_applied - a0) + pend_obs(), 12);
        idle(40);

        // Random traffic with biased phases to reach both saturation limits
        for (int k = 0; k < 400; k++) begin
            if (k % 40 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0: step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
                1: step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
                default: step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            endcase
        end
        idle(70);

        // Reset during a stretch with three retards still pending
        waited = 0;
        while ((m_phase() != 0 || m_stretch) && waited < 20) begin
            step(0, 0);
            waited++;
        end
        for (int k = 0; k < 4; k++) step(0, 1);
        chk("stretch_reached", int'(m_stretch), 1);
        chk("pre_rst_pend", pend_obs(), -3);
        do_reset();
        idle(22);
        void'(pers.pop_front());
        chk("post_rst_per", cnt_ne(pers, 4), 0);
        chk("post_rst_pend", pend_obs(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
